// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_pkg
// Purpose : Shared types and constants for the counter command sequencer:
//           FSM state encoding, default counter width, direction encoding.
// Ports   : (package - none)
// Revision: 1.0  initial release
// ============================================================================
package counter_pkg;

  // Default width of the counter, step count and shadow count.
  localparam int CNT_W = 8;

  // Direction encoding, identical to the counter's upndwn input.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // One-hot so that busy and other status bits decode from a single bit.
  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_IDLE  = 5'b00010,
    ST_CLEAR = 5'b00100,
    ST_RUN   = 5'b01000,
    ST_CHECK = 5'b10000
  } ctrl_state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_ctrl_cnt_shadow.sv
`default_nettype none
// ============================================================================
// Module  : cnt_shadow
// Purpose : Expected-count register that mirrors an up/down counter. It is
//           stepped by the same enable/direction the real counter sees, so
//           after any run it holds the value the counter should show.
// Ports   : clk_i      clock (posedge)
//           reset_n_i  asynchronous active-low reset, clears count
//           clear_i    synchronous clear (priority over enable)
//           enable_i   step the count on this edge
//           dir_i      0 = up, 1 = down
//           cnt_o      shadow count, wraps modulo 2^W
// Revision: 1.0  initial release
// ============================================================================
module cnt_shadow
  import counter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic         dir_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Plain modulo arithmetic: 0 - 1 wraps to all ones, all ones + 1 to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (dir_i == DIR_DN) begin
        cnt_d = cnt_q - C_ONE;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : cnt_shadow
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl
// Purpose : Command sequencer in front of an up/down counter. Accepts
//           "step N up/down" and "clear" commands over valid/ready, turns
//           each into an exact run of enable cycles (or a one-cycle counter
//           reset), tracks the expected count and compares it with the
//           counter output when each command completes.
// Ports   : clk_i          clock (posedge)
//           reset_n_i      asynchronous active-low reset
//           cmd_valid_i    command offered
//           cmd_ready_o    command accepted when valid & ready at posedge
//           cmd_clear_i    1 = clear command (dir/steps ignored)
//           cmd_dir_i      0 = up, 1 = down
//           cmd_steps_i    number of enable cycles to issue
//           abort_i        end a run early (the abort edge still steps)
//           cnt_in_i       counter's current count
//           ctr_enable_o   counter enable
//           ctr_upndwn_o   counter direction
//           ctr_reset_o    counter synchronous reset
//           exp_cnt_o      shadow expected count
//           busy_o         high whenever not idle
//           done_o         one-cycle pulse while checking
//           err_o          sticky count-mismatch flag
// Revision: 1.0  initial release
// ============================================================================
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_clear_i,
  input  logic         cmd_dir_i,
  input  logic [W-1:0] cmd_steps_i,
  input  logic         abort_i,
  input  logic [W-1:0] cnt_in_i,
  output logic         ctr_enable_o,
  output logic         ctr_upndwn_o,
  output logic         ctr_reset_o,
  output logic [W-1:0] exp_cnt_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam logic [W-1:0] C_ONE = W'(1);

  ctrl_state_e  state_q;
  logic [W-1:0] rem_q;
  logic         ctr_enable_q;
  logic         ctr_upndwn_q;
  logic         ctr_reset_q;
  logic         cmd_ready_q;
  logic         done_q;
  logic         err_q;

  logic         shadow_clear;
  logic [W-1:0] exp_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_INIT;
      rem_q        <= '0;
      ctr_enable_q <= 1'b0;
      ctr_upndwn_q <= DIR_UP;
      ctr_reset_q  <= 1'b1;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Pulses: only the state that wants them raises them again.
      done_q      <= 1'b0;
      ctr_reset_q <= 1'b0;

      case (state_q)
        ST_INIT: begin
          // The counter has seen ctr_reset high on this edge.
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end

        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_clear_i) begin
              state_q     <= ST_CLEAR;
              ctr_reset_q <= 1'b1;
            end else if (cmd_steps_i == '0) begin
              state_q <= ST_CHECK;
              done_q  <= 1'b1;
            end else begin
              state_q      <= ST_RUN;
              ctr_enable_q <= 1'b1;
              ctr_upndwn_q <= cmd_dir_i;
              rem_q        <= cmd_steps_i;
            end
          end
        end

        ST_CLEAR: begin
          // Counter and shadow both clear on this edge.
          state_q <= ST_CHECK;
          done_q  <= 1'b1;
        end

        ST_RUN: begin
          // Every edge here is a counted step, including an abort edge,
          // so the shadow and the counter stay in lockstep.
          rem_q <= rem_q - C_ONE;
          if ((rem_q == C_ONE) || abort_i) begin
            ctr_enable_q <= 1'b0;
            state_q      <= ST_CHECK;
            done_q       <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (cnt_in_i != exp_cnt) begin
            err_q <= 1'b1;
          end
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q      <= ST_INIT;
          ctr_enable_q <= 1'b0;
          ctr_reset_q  <= 1'b1;
          cmd_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shadow_clear = (state_q == ST_CLEAR);

  cnt_shadow #(
    .W (W)
  ) u_shadow (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (shadow_clear),
    .enable_i  (ctr_enable_q),
    .dir_i     (ctr_upndwn_q),
    .cnt_o     (exp_cnt)
  );

  assign cmd_ready_o  = cmd_ready_q;
  assign ctr_enable_o = ctr_enable_q;
  assign ctr_upndwn_o = ctr_upndwn_q;
  assign ctr_reset_o  = ctr_reset_q;
  assign exp_cnt_o    = exp_cnt;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule : counter_ctrl
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_ctrl
// Purpose : Directed self-checking bench for counter_ctrl with an attached
//           8-bit up/down counter model and an expected-result queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_counter_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_clear;
  logic         cmd_dir;
  logic [W-1:0] cmd_steps;
  logic         abort;
  logic [W-1:0] cnt_in;
  logic         ctr_enable;
  logic         ctr_upndwn;
  logic         ctr_reset;
  logic [W-1:0] exp_cnt;
  logic         busy;
  logic         done;
  logic         err;

  // Counter attached downstream, plus an override to inject a wrong count.
  logic [W-1:0] model_cnt = '0;
  logic         force_en  = 1'b0;
  logic [W-1:0] force_val = '0;

  assign cnt_in = force_en ? force_val : model_cnt;

  always @(posedge clk) begin
    if (ctr_reset)       model_cnt <= '0;
    else if (ctr_enable) model_cnt <= ctr_upndwn ? model_cnt - 8'd1 : model_cnt + 8'd1;
  end

  counter_ctrl #(.W(W)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_clear_i  (cmd_clear),
    .cmd_dir_i    (cmd_dir),
    .cmd_steps_i  (cmd_steps),
    .abort_i      (abort),
    .cnt_in_i     (cnt_in),
    .ctr_enable_o (ctr_enable),
    .ctr_upndwn_o (ctr_upndwn),
    .ctr_reset_o  (ctr_reset),
    .exp_cnt_o    (exp_cnt),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_in;
    logic         err;
    int           en;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] sb_cnt      = '0;
  logic         sb_err      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one command, push its expected outcome, wait for done, compare.
  task automatic run_cmd(input logic clr, input logic dir, input int steps, input int abort_at);
    exp_t e;
    exp_t g;
    int   n;
    int   n_en;
    int   cyc;
    int   bad_dir;
    bit   got;
    n = clr ? 0 : ((abort_at > 0 && abort_at < steps) ? abort_at : steps);
    if (clr)      sb_cnt = '0;
    else if (dir) sb_cnt = sb_cnt - W'(n);
    else          sb_cnt = sb_cnt + W'(n);
    e.cnt    = sb_cnt;
    e.cnt_in = force_en ? force_val : sb_cnt;
    e.err    = sb_err | (e.cnt_in != sb_cnt);
    sb_err   = e.err;
    e.en     = n;
    e.lat    = clr ? 2 : n + 1;
    sb.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_clear = clr;
    cmd_dir   = dir;
    cmd_steps = W'(steps);
    n_en    = 0;
    bad_dir = 0;
    got     = 1'b0;
    cyc     = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      if (ctr_enable) begin
        n_en++;
        if (ctr_upndwn !== dir) bad_dir++;
        if (abort_at > 0 && n_en == abort_at) abort = 1'b1;
      end
      if (done === 1'b1) got = 1'b1;
    end
    abort = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    g = sb.pop_front();
    chk("done_latency", cyc, g.lat);
    chk("enable_cycles", n_en, g.en);
    chk("enable_dir", bad_dir, 0);
    chk("exp_cnt", 32'(exp_cnt), 32'(g.cnt));
    chk("cnt_in", 32'(cnt_in), 32'(g.cnt_in));
    chk("busy_in_check", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("err", 32'(err), 32'(g.err));
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  int done_seen;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    abort     = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ctr_reset", 32'(ctr_reset), 32'd1);
    chk("rst_enable", 32'(ctr_enable), 32'd0);
    chk("rst_upndwn", 32'(ctr_upndwn), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exp_cnt", 32'(exp_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Release; INIT still drives ctr_reset until the first edge.
    reset_n = 1'b1;
    #1;
    chk("init_ctr_reset", 32'(ctr_reset), 32'd1);
    @(negedge clk);
    chk("idle_ctr_reset", 32'(ctr_reset), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cnt_in", 32'(cnt_in), 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_ready_hold", 32'(cmd_ready), 32'd1);

    // Abort while idle has no effect.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_enable", 32'(ctr_enable), 32'd0);

    run_cmd(1'b0, 1'b0, 5, 0);      // up 5 -> 5
    run_cmd(1'b1, 1'b0, 9, 0);      // clear -> 0
    run_cmd(1'b0, 1'b1, 3, 0);      // down 3 from 0 -> 253
    run_cmd(1'b1, 1'b0, 0, 0);      // clear -> 0
    run_cmd(1'b0, 1'b0, 200, 10);   // abort on 10th enable -> 10
    run_cmd(1'b0, 1'b0, 0, 0);      // zero steps -> 10, no enable
    run_cmd(1'b0, 1'b0, 250, 0);    // wrap through 255 -> 4
    run_cmd(1'b0, 1'b1, 1, 0);      // down 1 -> 3
    run_cmd(1'b1, 1'b0, 0, 0);      // clear -> 0

    // Wrong count from the counter: err sets and sticks.
    force_en  = 1'b1;
    force_val = 8'd7;
    run_cmd(1'b0, 1'b0, 0, 0);
    force_en = 1'b0;
    run_cmd(1'b0, 1'b0, 2, 0);

    // Reset mid-run: immediate return to INIT, command lost, no done.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_clear = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd50;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_run_enable", 32'(ctr_enable), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_enable", 32'(ctr_enable), 32'd0);
    chk("arst_ctr_reset", 32'(ctr_reset), 32'd1);
    chk("arst_exp_cnt", 32'(exp_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    chk("arst_no_done", done_seen, 0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    sb_cnt = '0;
    sb_err = 1'b0;
    run_cmd(1'b0, 1'b1, 1, 0);      // down 1 from 0 -> 255

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_counter_ctrl
`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Command sequencer directly upstream of the 8-bit up/down counter; it drives the counter's enable, upndwn and reset inputs. It accepts "step N up/down" or "clear" commands over a valid/ready handshake and converts each into an exact run of enable cycles. It keeps a shadow of the expected count and checks the counter's cnt output once each command completes.

Parameters:
W, 8, counter width; also the width of cmd_steps, exp_cnt and cnt_in.

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a posedge
cmd_clear  in  1  1 = clear command; cmd_dir and cmd_steps ignored
cmd_dir  in  1  0 = count up, 1 = count down (same encoding as the counter's upndwn)
cmd_steps  in  W  number of enable cycles to issue
abort  in  1  terminate a RUN early
cnt_in  in  W  counter's cnt output
ctr_enable  out  1  to counter enable
ctr_upndwn  out  1  to counter upndwn
ctr_reset  out  1  to counter reset (counter reset is synchronous, active-high)
exp_cnt  out  W  shadow expected count
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in CHECK
err  out  1  sticky mismatch flag

Behaviour:
- All outputs are registered or decoded from the one-hot state register; none depends combinationally on inputs.
- States: INIT, IDLE, CLEAR, RUN, CHECK.
- reset_n low (asynchronous): state = INIT, ctr_reset = 1, ctr_enable = 0, ctr_upndwn = 0, exp_cnt = 0, err = 0, done = 0, cmd_ready = 0, busy = 1.
- INIT: at the first posedge after reset_n rises, go to IDLE and drive ctr_reset to 0. The counter therefore sees reset on at least one edge.
- IDLE: cmd_ready = 1. On handshake:
  - cmd_clear = 1: go to CLEAR. cmd_clear takes priority over cmd_steps.
  - cmd_steps = 0: go straight to CHECK with no enable issued.
  - otherwise: latch dir, set rem = cmd_steps, go to RUN.
- CLEAR: ctr_reset = 1 for exactly one cycle; exp_cnt = 0. Then go to CHECK.
- RUN: ctr_enable = 1 and ctr_upndwn = dir for exactly rem cycles.
  - At each posedge with ctr_enable high, exp_cnt updates by +1 (up) or -1 (down), modulo 2^W, in the same edge the counter updates.
  - On the edge that consumes the last step, go to CHECK.
  - Timing: handshake at edge E0, enable high E0..EN, counter updates at E1..EN, CHECK occupies the cycle EN..EN+1.
- abort high at a posedge in RUN: that edge still counts as a step (the counter also updates on it). Then go to CHECK; ctr_enable is low from that edge. exp_cnt stays consistent with the counter.
- abort outside RUN is ignored.
- CHECK: done = 1 for one cycle. If cnt_in != exp_cnt, set err (stays set until reset_n). Return to IDLE.
- cmd_ready = 0 in INIT, CLEAR, RUN and CHECK, so back-to-back commands take at least N+2 cycles.
- Wrap: exp_cnt from 255 up 1 gives 0; from 0 down 1 gives 255. No saturation.
- reset_n asserted mid-RUN: immediate return to INIT, ctr_enable drops asynchronously, the command is lost and no done is issued.

Decomposition:
- counter_pkg holds:
  - state enum ctrl_state_e (INIT, IDLE, CLEAR, RUN, CHECK)
  - default width CNT_W = 8
  - direction constants DIR_UP = 0, DIR_DN = 1
- One sub-module, cnt_shadow: the expected-count register with clear, enable and dir inputs, so the same model can be reused for checking.

Test Plan:
- Release reset_n, then idle 3 cycles -> ctr_reset high on the first edge only, cmd_ready = 1 from the second cycle, exp_cnt = 0, err = 0.
- Up, steps = 5, with a counter model attached -> ctr_enable high for exactly 5 cycles, done 1 cycle later, exp_cnt = cnt_in = 5, err = 0.
- Clear, then down, steps = 3 -> exp_cnt = 253 (wrap), cnt_in = 253, err = 0.
- Up, steps = 200, with abort asserted on the 10th enable cycle -> exactly 10 enables, exp_cnt = 10, done pulses, err = 0.
- Steps = 0 -> no ctr_enable, done on the next cycle; then force cnt_in to 7 with exp_cnt = 0 on the next command -> err = 1 and stays 1.
- reset_n pulsed low mid-RUN (steps = 50) -> ctr_enable = 0 and ctr_reset = 1 immediately, no done, exp_cnt = 0.
